pipeline_fetch_stage: RTL
=========================

PIPELINE_FETCH_STAGE -- requirements
Module: pipeline_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16, consecutive unanswered request cycles before fetch_error is raised (legal range 2..255).
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port stall, input, 1, decode-stage hold (shouldStall from the controller).
REQ-006 Port redirect_valid, input, 1, taken jump/jal/jr/branch resolved downstream.
REQ-007 Port redirect_pc, input, 32, redirect target; bits [1:0] ignored.
REQ-008 Port imem_req, output, 1, instruction-memory request.
REQ-009 Port imem_addr, output, 32, word-aligned fetch address.
REQ-010 Port imem_rdata, input, 32, instruction word, valid only when imem_ready=1.
REQ-011 Port imem_ready, input, 1, memory ready (MIO_ready); rdata corresponds to current imem_addr.
REQ-012 Port if_id_valid, output, 1, IF/ID register holds a live instruction.
REQ-013 Port if_id_instruction, output, 32, instruction presented to decode.
REQ-014 Port if_id_pc_plus4, output, 32, address of the fetched instruction + 4.
REQ-015 Port fetch_error, output, 1, sticky memory-timeout flag.

Function
REQ-016 The block SHALL keep a 32-bit PC with bits [1:0] always 00; imem_addr SHALL equal PC combinationally.
REQ-017 imem_req SHALL be 1 in every non-reset cycle in which fetch_error=0, and 0 once fetch_error=1.
REQ-018 Accept condition: imem_req & imem_ready & !stall & !redirect_valid; on accept, the IF/ID register SHALL load {valid=1, instruction=imem_rdata, pc_plus4=PC+4} and PC SHALL become PC+4 on the same edge (1-cycle latency, one instruction per cycle at full throughput).
REQ-019 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 Cycle with redirect_valid=1: PC SHALL load {redirect_pc[31:2],2'b00}; IF/ID SHALL flush to valid=0, instruction=NOP (32'h0000_0000), pc_plus4 unchanged; any imem_rdata that cycle SHALL be discarded; redirect SHALL win over stall and imem_ready.
REQ-021 Cycle with stall=1 and redirect_valid=0: PC and entire IF/ID register SHALL hold; returned data SHALL be ignored (memory re-reads same address next cycle).
REQ-022 Cycle with stall=0, redirect_valid=0, imem_ready=0: PC holds; IF/ID SHALL load valid=0, instruction=NOP (bubble inserted).
REQ-023 A wait counter SHALL count cycles with imem_req=1 & imem_ready=0; it SHALL clear on any cycle with imem_ready=1 or redirect_valid=1; stall does not clear it.
REQ-024 When the wait counter reaches TIMEOUT, fetch_error SHALL be set on that edge and remain 1 until reset; while set, no accept occurs and IF/ID holds bubbles (redirects still update PC).
REQ-025 Two-state FSM: RUN (normal) and ERROR (fetch_error=1); RUN->ERROR on timeout; ERROR exits only via rst.

Reset
REQ-026 On rst=1 (asynchronous, no clock needed): PC=RESET_PC, if_id_valid=0, if_id_instruction=32'h0, if_id_pc_plus4=32'h0, wait counter=0, fetch_error=0, FSM=RUN.
REQ-027 On the first clk edge after rst deasserts, imem_addr SHALL already equal RESET_PC with imem_req=1; reset mid-stall or mid-wait SHALL discard all in-flight state.

Structure
REQ-028 NOP encoding and the RESET_PC default SHALL live in the shared constants header alongside the opcode/func codes.
REQ-029 The IF/ID register (valid, instruction, pc_plus4 with load/hold/flush controls) SHALL be a sub-module named if_id_reg; PC, wait counter and FSM stay in the top.

Verification
REQ-030 Reset release, imem_ready=1 constantly, rdata=0x20080005,0x20090007,... -> if_id_pc_plus4 = 0x4,0x8,0xC on consecutive cycles, if_id_instruction matches, if_id_valid=1 from cycle 1.
REQ-031 stall=1 for 3 cycles with PC=0x8 -> imem_addr stays 0x8, IF/ID unchanged all 3 cycles, resumes with 0x8 accepted after stall drops.
REQ-032 redirect_valid=1, redirect_pc=0x0000_0043, stall=1, imem_ready=1 same cycle -> next cycle PC=0x40, if_id_valid=0, instruction=0x0.
REQ-033 imem_ready=0 for 2 cycles then 1 -> two bubbles (valid=0, instruction=0), then correct instruction; fetch_error stays 0.
REQ-034 TIMEOUT=4, imem_ready held 0 -> fetch_error=1 after 4th waiting edge, imem_req=0 afterwards; rst pulse mid-cycle clears it immediately.
REQ-035 PC=0xFFFF_FFFC accepted -> if_id_pc_plus4=0x0, next imem_addr=0x0.

Source files
------------

// File: rtl/pipeline_fetch_stage_pkg.sv
// Shared constants for the fetch stage: NOP encoding, reset PC, opcode/func
// codes and the fetch FSM state type.
package pipeline_fetch_stage_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;
  localparam logic [5:0] FUNC_ADD = 6'b100000;

  typedef enum logic {
    RUN   = 1'b0,
    ERROR = 1'b1
  } fetchState_e;

endpackage

// File: rtl/pipeline_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load wins over flush; flush inserts a NOP bubble
// but keeps pcPlus4; otherwise holds.
module if_id_reg
  import pipeline_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcPlus4In,
  output logic        valid,
  output logic [31:0] instruction,
  output logic [31:0] pcPlus4
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= 1'b0;
      instruction <= NOP;
      pcPlus4     <= 32'h0;
    end else if (load) begin
      valid       <= 1'b1;
      instruction <= instrIn;
      pcPlus4     <= pcPlus4In;
    end else if (flush) begin
      valid       <= 1'b0;
      instruction <= NOP;
    end
  end

endmodule

// File: rtl/pipeline_fetch_stage.sv
// Instruction fetch stage: PC, memory-wait watchdog with sticky error FSM,
// and the IF/ID register.
module pipeline_fetch_stage
  import pipeline_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        if_id_valid,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        fetch_error
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  fetchState_e state, stateNext;
  logic [31:0] pc, pcPlus4, redirectTarget;
  logic [7:0]  waitCnt;
  logic        accept, waiting, flush;

  assign fetch_error    = (state == ERROR);
  assign imem_req       = !fetch_error;
  assign imem_addr      = pc;
  assign pcPlus4        = pc + 32'd4;
  assign redirectTarget = redirect_pc & ~32'h3;
  assign accept         = imem_req & imem_ready & !stall & !redirect_valid;
  assign waiting        = imem_req & !imem_ready;
  // Not accepting and not stalled means a bubble; error state never holds live work.
  assign flush          = redirect_valid | fetch_error | (!stall & !accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pc      <= RESET_PC;
      waitCnt <= 8'd0;
    end else begin
      state <= stateNext;
      if (redirect_valid)  pc <= redirectTarget;
      else if (accept)     pc <= pcPlus4;
      if (imem_ready | redirect_valid) waitCnt <= 8'd0;
      else if (waiting)                waitCnt <= waitCnt + 8'd1;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (waiting && !redirect_valid && waitCnt == WAIT_LAST) stateNext = ERROR;
      ERROR:   stateNext = ERROR;
      default: stateNext = RUN;
    endcase
  end

  if_id_reg uIfId (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .flush      (flush),
    .instrIn    (imem_rdata),
    .pcPlus4In  (pcPlus4),
    .valid      (if_id_valid),
    .instruction(if_id_instruction),
    .pcPlus4    (if_id_pc_plus4)
  );

endmodule
